// File: rtl/train_scheduler.sv
// Run sequencer for the backprop training datapath: M renewals of N clocks each,
// cycling through P samples, with a host hold that freezes all counters.
module train_scheduler #(
  parameter int N = 13,
  parameter int M = 10000,
  parameter int P = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  output logic [3:0]  phase,
  output logic [1:0]  sample_idx,
  output logic        load_sample,
  output logic        update_en,
  output logic [15:0] iter_count,
  output logic        busy,
  output logic        done
);

  // iter_count must be able to reach M, so a 16-bit counter limits M to 65535.
  localparam int          M_CAP     = (M > 65535) ? 65535 : M;
  localparam logic [3:0]  PH_LAST   = 4'(N - 1);
  localparam logic [1:0]  SMP_LAST  = 2'(P - 1);
  localparam logic [15:0] ITER_LAST = 16'(M_CAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_phase;
  logic [1:0]  r_sample_idx;
  logic [15:0] r_iter_count;

  logic w_run;
  logic w_advance;
  logic w_phase_last;

  assign w_run        = (r_state == S_RUN);
  assign w_advance    = w_run && !hold;
  assign w_phase_last = (r_phase == PH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_phase      <= 4'd0;
      r_sample_idx <= 2'd0;
      r_iter_count <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_RUN;
            r_phase      <= 4'd0;
            r_sample_idx <= 2'd0;
            r_iter_count <= 16'd0;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (w_phase_last) begin
              r_phase      <= 4'd0;
              r_iter_count <= r_iter_count + 16'd1;
              if (r_iter_count == ITER_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_sample_idx <= (r_sample_idx == SMP_LAST) ? 2'd0 : r_sample_idx + 2'd1;
              end
            end else begin
              r_phase <= r_phase + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are same-cycle decodes so a held cycle simply defers them.
  assign load_sample = w_advance && (r_phase == 4'd0);
  assign update_en   = w_advance && w_phase_last;

  assign phase      = r_phase;
  assign sample_idx = r_sample_idx;
  assign iter_count = r_iter_count;
  assign busy       = w_run;
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_train_scheduler.sv
// Directed bench for train_scheduler: three instances with different N/M/P
// share the same control inputs and are exercised one at a time.
module tb_train_scheduler;

  logic clk = 1'b0;
  logic reset, start, hold;

  logic [3:0]  a_phase, b_phase, c_phase;
  logic [1:0]  a_sidx, b_sidx, c_sidx;
  logic        a_load, b_load, c_load;
  logic        a_upd, b_upd, c_upd;
  logic [15:0] a_iter, b_iter, c_iter;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  train_scheduler #(.N(13), .M(3), .P(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .phase(a_phase), .sample_idx(a_sidx), .load_sample(a_load), .update_en(a_upd),
    .iter_count(a_iter), .busy(a_busy), .done(a_done)
  );

  train_scheduler #(.N(4), .M(6), .P(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .phase(b_phase), .sample_idx(b_sidx), .load_sample(b_load), .update_en(b_upd),
    .iter_count(b_iter), .busy(b_busy), .done(b_done)
  );

  train_scheduler #(.N(13), .M(2), .P(4)) dut_c (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .phase(c_phase), .sample_idx(c_sidx), .load_sample(c_load), .update_en(c_upd),
    .iter_count(c_iter), .busy(c_busy), .done(c_done)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int upd_cnt;
  int exp_sidx_b [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; start = 1'b1; hold = 1'b1;

    // Reset held two edges with start and hold both high
    @(negedge clk);
    step();
    #1;
    check_val("rst_phase", a_phase, 0);
    check_val("rst_sidx", a_sidx, 0);
    check_val("rst_load", a_load, 0);
    check_val("rst_upd", a_upd, 0);
    check_val("rst_iter", a_iter, 0);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_done", a_done, 0);
    check_val("rst_busy_b", b_busy, 0);
    check_val("rst_busy_c", c_busy, 0);
    reset = 1'b0; hold = 1'b0;
    step();
    start = 1'b0;
    #1;
    check_val("post_rst_busy", a_busy, 1);
    check_val("post_rst_phase", a_phase, 0);
    check_val("post_rst_load", a_load, 1);

    // Basic run N=13 M=3 P=4
    do_reset();
    pulse_start();
    for (int c = 1; c <= 41; c++) begin
      #1;
      check_val("a_load", a_load, int'(c == 1 || c == 14 || c == 27));
      check_val("a_upd", a_upd, int'(c == 13 || c == 26 || c == 39));
      check_val("a_busy", a_busy, int'(c <= 39));
      check_val("a_done", a_done, int'(c >= 40));
      if (c <= 39) check_val("a_phase", a_phase, (c - 1) % 13);
      if (c == 1 || c == 14 || c == 27) check_val("a_sidx", a_sidx, (c - 1) / 13);
      if (c == 40) begin
        check_val("a_iter_done", a_iter, 3);
        check_val("a_phase_done", a_phase, 0);
      end
      step();
    end

    // Sample wrap N=4 M=6 P=4
    do_reset();
    pulse_start();
    upd_cnt = 0;
    for (int c = 1; c <= 26; c++) begin
      #1;
      if (b_upd) upd_cnt++;
      if ((c - 1) % 4 == 0 && c <= 21) begin
        check_val("b_load", b_load, 1);
        check_val("b_sidx", b_sidx, exp_sidx_b[(c - 1) / 4]);
      end
      check_val("b_done", b_done, int'(c >= 25));
      if (c == 25) begin
        check_val("b_iter_done", b_iter, 6);
        check_val("b_sidx_done", b_sidx, 1);
      end
      step();
    end
    check_val("b_upd_count", upd_cnt, 6);

    // Hold N=13 M=2: 3 cycles at phase 5, 2 cycles at phase 12
    do_reset();
    pulse_start();
    for (int c = 1; c <= 33; c++) begin
      hold = ((c >= 6 && c <= 8) || c == 16 || c == 17);
      #1;
      if (c >= 6 && c <= 9) check_val("c_phase_h5", c_phase, 5);
      if (c >= 16 && c <= 18) check_val("c_phase_h12", c_phase, 12);
      check_val("c_upd", c_upd, int'(c == 18 || c == 31));
      check_val("c_load", c_load, int'(c == 1 || c == 19));
      check_val("c_done", c_done, int'(c >= 32));
      if (c == 19) check_val("c_iter_r1", c_iter, 1);
      if (c == 32) check_val("c_iter_done", c_iter, 2);
      step();
    end
    hold = 1'b0;

    // Start while busy has no effect; restart from DONE
    do_reset();
    pulse_start();
    for (int c = 1; c <= 41; c++) begin
      start = (c == 8);
      #1;
      check_val("a2_upd", a_upd, int'(c == 13 || c == 26 || c == 39));
      if (c == 9) begin
        check_val("a2_phase", a_phase, 8);
        check_val("a2_iter", a_iter, 0);
        check_val("a2_sidx", a_sidx, 0);
        check_val("a2_busy", a_busy, 1);
      end
      if (c == 40) begin
        check_val("a2_done", a_done, 1);
        check_val("a2_iter_done", a_iter, 3);
        check_val("a2_sidx_done", a_sidx, 2);
      end
      step();
    end
    start = 1'b0;
    pulse_start();
    #1;
    check_val("rs_busy", a_busy, 1);
    check_val("rs_done", a_done, 0);
    check_val("rs_iter", a_iter, 0);
    check_val("rs_phase", a_phase, 0);
    check_val("rs_sidx", a_sidx, 0);
    check_val("rs_load", a_load, 1);

    // Reset mid-run at iter_count=1, phase=6
    step();
    for (int c = 2; c <= 19; c++) begin
      #1;
      check_val("mr_upd", a_upd, int'(c == 13));
      step();
    end
    #1;
    check_val("mr_phase_pre", a_phase, 6);
    check_val("mr_iter_pre", a_iter, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_val("mr_phase", a_phase, 0);
    check_val("mr_sidx", a_sidx, 0);
    check_val("mr_iter", a_iter, 0);
    check_val("mr_busy", a_busy, 0);
    check_val("mr_done", a_done, 0);
    check_val("mr_load", a_load, 0);
    for (int c = 0; c < 20; c++) begin
      check_val("mr_idle_upd", a_upd, 0);
      check_val("mr_idle_busy", a_busy, 0);
      step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/train_scheduler.md
# train_scheduler

Sequencer for the backpropagation training datapath. It accepts a start pulse and then runs M parameter renewals of N clocks each. For every renewal it drives a phase count, a training-sample index, a sample-load strobe and a weight-update strobe. It replaces the free-running phase counter: the phase now starts and stops under control, and a hold input lets the host stall training between or within renewals.

## Interface

Parameters:
- N, 13: clocks per renewal. 2 ≤ N ≤ 16.
- M, 10000: renewals per training run. 1 ≤ M ≤ 65536.
- P, 4: number of training samples, cycled in order. 1 ≤ P ≤ 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request to begin a run; sampled only in IDLE or DONE.
- hold  in  1  stall; while high in RUN, all counters freeze.
- phase  out  4  position inside the current renewal, 0..N-1; 0 outside RUN.
- sample_idx  out  2  training sample for the current renewal, 0..P-1.
- load_sample  out  1  strobe: latch inputs/targets (k1, k2, t1, t2) for sample_idx.
- update_en  out  1  strobe: commit weight/bias update.
- iter_count  out  16  renewals completed in the current run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level, not pulse).

## Operation

- States: IDLE, RUN, DONE, held in a registered state variable. phase, sample_idx and iter_count are registers.
- Reset: state=IDLE, phase=0, sample_idx=0, iter_count=0. All outputs are 0 in the cycle after reset is sampled high. Reset overrides start and hold, and aborts a run at any point.
- IDLE, start=1 → RUN. phase, sample_idx and iter_count are cleared.
- IDLE, start=0 → remain in IDLE.
- RUN, hold=1: no register changes. load_sample and update_en are forced to 0.
- RUN, hold=0, phase<N-1: phase increments by 1.
- RUN, hold=0, phase=N-1: phase wraps to 0.
  - If iter_count=M-1: iter_count becomes M, state → DONE, phase → 0.
  - Otherwise: iter_count increments, and sample_idx = (sample_idx=P-1) ? 0 : sample_idx+1.
- load_sample = (state=RUN) & (phase=0) & !hold. This is a combinational decode of registers.
- update_en = (state=RUN) & (phase=N-1) & !hold. This is a combinational decode of registers.
- busy = (state=RUN). done = (state=DONE).
- start in RUN is ignored; there is no restart mid-run.
- DONE, start=1 → RUN, with all counters cleared, exactly as from IDLE.
- DONE, start=0 → remain in DONE. iter_count holds at M and sample_idx keeps its last value.
- Width rules:
  - iter_count is 16-bit. The value M=65536 is not representable, so M is capped at 65535 in practice; comparisons use M-1.
  - phase is 4-bit, compared against N-1.
  - sample_idx is 2-bit, compared against P-1. With P=1 it stays at 0.

## Timing

- start high at edge T: from cycle T+1, busy=1, phase=0 and load_sample=1.
- Without hold, update_en is high in cycles T+N, T+2N, …, T+M·N.
- The final update_en is in cycle T+M·N. done=1 and busy=0 from cycle T+M·N+1.
- Each cycle in which hold=1 during RUN delays every later event by exactly one cycle.
- hold asserted in a phase-0 or phase-(N-1) cycle suppresses that strobe. The strobe is issued in the first cycle after hold drops.
- Strobes have zero latency relative to phase. Downstream logic acts on them in the same cycle.
- A strobe never repeats within a renewal and is never lost because of hold.

## Test plan

- Reset: hold reset for 2 cycles with start=1 and hold=1 → all outputs 0, state IDLE. After reset is released with start=1, busy=1 in the next cycle.
- Basic run (N=13, M=3, P=4): start pulse at T →
  - load_sample in cycles T+1, T+14, T+27;
  - update_en in cycles T+13, T+26, T+39;
  - sample_idx 0, 1, 2;
  - done=1 and iter_count=3 at T+40.
- Sample wrap (N=4, M=6, P=4): sample_idx sequence 0,1,2,3,0,1, and 6 update_en pulses total.
- Hold (N=13, M=2): assert hold for 3 cycles while phase=5, then for 2 cycles while phase=12 →
  - phase stays frozen at 5, then at 12;
  - exactly one update_en per renewal, each issued after hold drops;
  - done at T+2·13+5+1.
- Start while busy, then restart: pulse start at phase 7 of renewal 0 → no effect on any counter. After done, pulse start → busy=1, iter_count=0, phase=0, sample_idx=0 in the next cycle.
- Reset mid-run: assert reset at iter_count=1, phase=6 → all outputs 0 in the following cycle. No update_en is issued; IDLE is held until the next start.
